// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder.
//   - state_e : responder FSM encoding (idle, RAM access, read capture, response)
//   - CntW    : width of the wrapping event counters
package mem_responder_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StAccess  = 2'd1,
      StCapture = 2'd2,
      StResp    = 2'd3
   } state_e;

   localparam int unsigned CntW = 16;

endpackage

// File: rtl/mem_responder_event_counter.sv
// Wrapping event counter with increment enable.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset, clears the count
//   inc_i   : add one to the count on the next rising edge
//   count_o : current count, wraps from all-ones to zero
module mem_responder_event_counter
   import mem_responder_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            inc_i,
   output logic [CntW-1:0] count_o
);

   logic [CntW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i) begin
         count_d = count_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one read/write request at a time over a valid/ready
// handshake, performs it on a synchronous single-port RAM and returns the result on a
// response valid/ready channel. Out-of-range addresses return an error without touching
// the RAM. Completed reads, writes and errors are counted.
// Ports:
//   clk_i, rst_ni                  : clock, asynchronous active-low reset
//   req_valid_i / req_ready_o      : request handshake (ready only while idle)
//   req_we_i, req_addr_i,
//   req_wdata_i                    : request type, address and write data
//   rsp_valid_o / rsp_ready_i      : response handshake
//   rsp_rdata_o, rsp_err_o         : read data (write data echoed for writes), range error
//   mem_we_o, mem_addr_o,
//   mem_din_o, mem_dout_i          : RAM port; mem_dout_i valid one cycle after the address
//   rd_count_o, wr_count_o,
//   err_count_o                    : wrapping completion counters
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned SIZE   = 16,
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DEPTH  = 1024
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [SIZE-1:0]   req_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [SIZE-1:0]   rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [SIZE-1:0]   mem_din_o,
   input  logic [SIZE-1:0]   mem_dout_i,
   output logic [CntW-1:0]   rd_count_o,
   output logic [CntW-1:0]   wr_count_o,
   output logic [CntW-1:0]   err_count_o
);

   state_e            state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [SIZE-1:0]   mem_din_q, mem_din_d;
   logic [SIZE-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;

   logic addr_err;
   logic rsp_done;

   assign addr_err = (32'(req_addr_i) >= DEPTH);

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      mem_addr_d  = mem_addr_q;
      mem_din_d   = mem_din_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      unique case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               we_d = req_we_i;
               if (addr_err) begin
                  state_d     = StResp;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end else begin
                  // The RAM-facing registers double as the latched request, so mem_addr
                  // and mem_din only move when a valid access is accepted.
                  state_d    = StAccess;
                  mem_addr_d = req_addr_i;
                  if (req_we_i) begin
                     mem_din_d = req_wdata_i;
                  end
               end
            end
         end
         StAccess: begin
            if (we_q) begin
               state_d     = StResp;
               rsp_rdata_d = mem_din_q;
               rsp_err_d   = 1'b0;
            end else begin
               state_d = StCapture;
            end
         end
         StCapture: begin
            state_d     = StResp;
            rsp_rdata_d = mem_dout_i;
            rsp_err_d   = 1'b0;
         end
         StResp: begin
            if (rsp_ready_i) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         we_q        <= 1'b0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         we_q        <= we_d;
         mem_addr_q  <= mem_addr_d;
         mem_din_q   <= mem_din_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Decoded straight from the state register so a reset drops them without waiting
   // for a clock edge.
   assign req_ready_o = (state_q == StIdle);
   assign rsp_valid_o = (state_q == StResp);
   assign mem_we_o    = (state_q == StAccess) && we_q;

   assign mem_addr_o  = mem_addr_q;
   assign mem_din_o   = mem_din_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

   assign rsp_done = rsp_valid_o && rsp_ready_i;

   mem_responder_event_counter u_rd_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc_i   (rsp_done && !rsp_err_q && !we_q),
      .count_o (rd_count_o)
   );

   mem_responder_event_counter u_wr_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc_i   (rsp_done && !rsp_err_q && we_q),
      .count_o (wr_count_o)
   );

   mem_responder_event_counter u_err_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc_i   (rsp_done && rsp_err_q),
      .count_o (err_count_o)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a behavioural synchronous RAM (DEPTH = 512).
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [9:0]  req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid, rsp_ready;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [15:0] mem_din;
   logic [15:0] mem_dout;
   logic [15:0] rd_count, wr_count, err_count;

   logic [15:0] ram [0:1023];
   int          we_cycles = 0;
   int          passed = 0;
   int          total = 0;

   always #5 clk = ~clk;

   // Synchronous single-port RAM: read data appears one cycle after the address.
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
      if (mem_we) we_cycles <= we_cycles + 1;
   end

   mem_responder #(
      .SIZE   (16),
      .ADDR_W (10),
      .DEPTH  (512)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_we_i    (req_we),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_din_o   (mem_din),
      .mem_dout_i  (mem_dout),
      .rd_count_o  (rd_count),
      .wr_count_o  (wr_count),
      .err_count_o (err_count)
   );

   // Issue one request from idle; scramble req_* right after acceptance. lat counts the
   // accept edge as 1 and stops at the edge after which rsp_valid is seen (capped at 20).
   task automatic do_req(input logic we, input logic [9:0] addr, input logic [15:0] wdata,
                         output int lat);
      int guard;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_valid = 1'b1;
      guard = 0;
      while (!req_ready && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr  = ~addr;
      req_wdata = ~wdata;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      total++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || mem_we !== 1'b0) begin
         $display("FAIL reset_ctrl: rdy=%b vld=%b err=%b we=%b, need 1 0 0 0",
                  req_ready, rsp_valid, rsp_err, mem_we);
      end else passed++;
      total++;
      if (rsp_rdata !== 16'h0 || mem_addr !== 10'h0 || mem_din !== 16'h0) begin
         $display("FAIL reset_data: rdata=%h addr=%h din=%h, need 0 0 0",
                  rsp_rdata, mem_addr, mem_din);
      end else passed++;
      total++;
      if (rd_count !== 16'h0 || wr_count !== 16'h0 || err_count !== 16'h0) begin
         $display("FAIL reset_cnt: rd=%h wr=%h err=%h, need 0 0 0", rd_count, wr_count, err_count);
      end else passed++;
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_write_read();
      int lat;
      we_cycles = 0;
      do_req(1'b1, 10'h005, 16'hA5C3, lat);
      total++;
      if (lat !== 2) $display("FAIL wr_latency: got %0d, need 2", lat); else passed++;
      total++;
      if (rsp_rdata !== 16'hA5C3 || rsp_err !== 1'b0) begin
         $display("FAIL wr_rsp: rdata=%h err=%b, need a5c3 0", rsp_rdata, rsp_err);
      end else passed++;
      finish_rsp();
      do_req(1'b0, 10'h005, 16'h0000, lat);
      total++;
      if (lat !== 3) $display("FAIL rd_latency: got %0d, need 3", lat); else passed++;
      total++;
      if (rsp_rdata !== 16'hA5C3 || rsp_err !== 1'b0) begin
         $display("FAIL rd_rsp: rdata=%h err=%b, need a5c3 0", rsp_rdata, rsp_err);
      end else passed++;
      finish_rsp();
      total++;
      if (wr_count !== 16'd1 || rd_count !== 16'd1 || err_count !== 16'd0) begin
         $display("FAIL wr_rd_cnt: wr=%0d rd=%0d err=%0d, need 1 1 0", wr_count, rd_count, err_count);
      end else passed++;
      total++;
      if (we_cycles !== 1) $display("FAIL wr_we_cycles: got %0d, need 1", we_cycles); else passed++;
   endtask

   task automatic test_error();
      int lat;
      we_cycles = 0;
      do_req(1'b0, 10'h200, 16'h0000, lat);
      total++;
      if (lat !== 1) $display("FAIL err_latency: got %0d, need 1", lat); else passed++;
      total++;
      if (rsp_err !== 1'b1 || rsp_rdata !== 16'h0) begin
         $display("FAIL err_rsp: err=%b rdata=%h, need 1 0000", rsp_err, rsp_rdata);
      end else passed++;
      finish_rsp();
      total++;
      if (we_cycles !== 0 || mem_addr !== 10'h005) begin
         $display("FAIL err_no_mem: we_cycles=%0d addr=%h, need 0 005", we_cycles, mem_addr);
      end else passed++;
      total++;
      if (err_count !== 16'd1 || rd_count !== 16'd1 || wr_count !== 16'd1) begin
         $display("FAIL err_cnt: err=%0d rd=%0d wr=%0d, need 1 1 1", err_count, rd_count, wr_count);
      end else passed++;
   endtask

   task automatic test_back_to_back();
      int   lat;
      logic stable;
      do_req(1'b0, 10'h005, 16'h0000, lat);
      total++;
      if (lat !== 3) $display("FAIL bp_rd_latency: got %0d, need 3", lat); else passed++;
      // Next request presented while the response is stalled.
      req_we    = 1'b1;
      req_addr  = 10'h020;
      req_wdata = 16'h0BEE;
      req_valid = 1'b1;
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hA5C3 || req_ready !== 1'b0) stable = 1'b0;
      end
      total++;
      if (stable !== 1'b1) begin
         $display("FAIL bp_stable: vld=%b rdata=%h rdy=%b, need 1 a5c3 0 for 5 cycles",
                  rsp_valid, rsp_rdata, req_ready);
      end else passed++;
      finish_rsp();
      total++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         $display("FAIL bp_idle: rdy=%b vld=%b, need 1 0", req_ready, rsp_valid);
      end else passed++;
      @(posedge clk); #1;
      req_valid = 1'b0;
      total++;
      if (req_ready !== 1'b0) $display("FAIL bp_accept: rdy=%b, need 0", req_ready); else passed++;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      total++;
      if (lat !== 2 || rsp_rdata !== 16'h0BEE) begin
         $display("FAIL bp_wr_rsp: lat=%0d rdata=%h, need 2 0bee", lat, rsp_rdata);
      end else passed++;
      finish_rsp();
      total++;
      if (rd_count !== 16'd2 || wr_count !== 16'd2) begin
         $display("FAIL bp_cnt: rd=%0d wr=%0d, need 2 2", rd_count, wr_count);
      end else passed++;
   endtask

   task automatic test_hold_change();
      int lat;
      we_cycles = 0;
      do_req(1'b1, 10'h010, 16'h1234, lat);
      total++;
      if (lat !== 2 || rsp_rdata !== 16'h1234) begin
         $display("FAIL hold_rsp: lat=%0d rdata=%h, need 2 1234", lat, rsp_rdata);
      end else passed++;
      finish_rsp();
      total++;
      if (ram[10'h010] !== 16'h1234) begin
         $display("FAIL hold_ram: got %h, need 1234", ram[10'h010]);
      end else passed++;
      total++;
      if (we_cycles !== 1) $display("FAIL hold_we_cycles: got %0d, need 1", we_cycles); else passed++;
      do_req(1'b0, 10'h010, 16'h0000, lat);
      total++;
      if (rsp_rdata !== 16'h1234) $display("FAIL hold_readback: got %h, need 1234", rsp_rdata);
      else passed++;
      finish_rsp();
   endtask

   task automatic test_reset_mid();
      req_we    = 1'b1;
      req_addr  = 10'h030;
      req_wdata = 16'h5555;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      total++;
      if (mem_we !== 1'b1) $display("FAIL rstmid_access: mem_we=%b, need 1", mem_we); else passed++;
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (mem_we !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         $display("FAIL rstmid_async: we=%b vld=%b rdy=%b, need 0 0 1", mem_we, rsp_valid, req_ready);
      end else passed++;
      total++;
      if (rd_count !== 16'h0 || wr_count !== 16'h0 || err_count !== 16'h0) begin
         $display("FAIL rstmid_cnt: rd=%h wr=%h err=%h, need 0 0 0", rd_count, wr_count, err_count);
      end else passed++;
      #2;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (rsp_valid !== 1'b0 || wr_count !== 16'h0) begin
         $display("FAIL rstmid_after: vld=%b wr=%h, need 0 0", rsp_valid, wr_count);
      end else passed++;
   endtask

   task automatic test_wrap();
      int lat;
      force dut.u_wr_cnt.count_q = 16'hFFFF;
      #1;
      release dut.u_wr_cnt.count_q;
      @(posedge clk); #1;
      total++;
      if (wr_count !== 16'hFFFF) $display("FAIL wrap_preload: got %h, need ffff", wr_count);
      else passed++;
      do_req(1'b1, 10'h040, 16'hCAFE, lat);
      finish_rsp();
      total++;
      if (wr_count !== 16'h0000 || rd_count !== 16'h0) begin
         $display("FAIL wrap: wr=%h rd=%h, need 0000 0000", wr_count, rd_count);
      end else passed++;
   endtask

   initial begin
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b0;
      test_reset();
      test_write_read();
      test_error();
      test_back_to_back();
      test_hold_change();
      test_reset_mid();
      test_wrap();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, need completion");
      $fatal(1);
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU datapath's memory interface: accepts single read/write requests from an initiator (FSM or CPU) over a valid/ready handshake and performs them on a synchronous single-port block RAM.
- Returns read data or write acknowledgement over a response valid/ready channel, and flags out-of-range addresses as errors.
- Sits between the initiator and the memory instance; keeps event counters that a board top can route to LEDs or 7-segment displays.

Parameters:
- SIZE, 16, data width in bits
- ADDR_W, 10, address width in bits
- DEPTH, 1024, number of implemented words; must be ≤ 2^ADDR_W; addresses ≥ DEPTH are errors

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  initiator has a request
- req_ready  out  1  responder can accept; high only in IDLE
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address
- req_wdata  in  SIZE  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  initiator consumes the response
- rsp_rdata  out  SIZE  read data; for writes, echoes the written data
- rsp_err  out  1  address out of range
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_din  out  SIZE  RAM write data
- mem_dout  in  SIZE  RAM read data; valid one cycle after the address is sampled
- rd_count  out  16  completed reads, wrapping
- wr_count  out  16  completed writes, wrapping
- err_count  out  16  error responses, wrapping

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, and all outputs go to 0 except req_ready=1. This includes rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_din and all three counters.
- States: IDLE, ACCESS, CAPTURE, RESP.
- Request acceptance: a request is accepted on a rising edge where req_valid && req_ready. At that edge the responder latches req_we, req_addr and req_wdata into internal registers.
  - Address ≥ DEPTH: go to RESP with rsp_err=1 and rsp_rdata=0. The memory is never accessed.
  - Otherwise: go to ACCESS.
- ACCESS (1 cycle):
  - mem_addr = latched address.
  - Write: mem_we=1 and mem_din = latched data. Next state is RESP with rsp_rdata = latched data and rsp_err=0.
  - Read: mem_we=0. Next state is CAPTURE.
- CAPTURE (1 cycle): mem_we=0. At the end edge, rsp_rdata ← mem_dout, rsp_err=0, and next state is RESP.
- mem_we is high only during ACCESS for writes and is never asserted in any other state.
- Latency from the accept edge to rsp_valid high:
  - read: 3 edges
  - write: 2 edges
  - error: 1 edge
- RESP:
  - rsp_valid=1, and rsp_rdata/rsp_err are held stable until rsp_valid && rsp_ready at an edge.
  - At that edge: go to IDLE, clear rsp_valid, and increment exactly one counter (rd_count, wr_count or err_count, by request type).
  - rsp_ready=1 already present on the first RESP cycle completes the response at that cycle's edge.
- req_ready is 0 in ACCESS, CAPTURE and RESP. Requests presented then are ignored; the initiator must hold them.
- The next request can be accepted no earlier than the edge after the response completes, giving one IDLE cycle minimum.
- Counters wrap from 0xFFFF to 0x0000.
- Changes to req_* after acceptance have no effect on the operation in progress.
- rsp_ready while rsp_valid=0 is ignored.
- Reset mid-operation aborts the operation:
  - An in-flight write may or may not have been committed, but mem_we drops asynchronously.
  - No response is produced and no counter is incremented.
- mem_addr and mem_din hold their last values outside ACCESS.

Decomposition:
- Shared package: state encoding constants (IDLE, ACCESS, CAPTURE, RESP) and the counter width constant (16).
- One natural sub-module: event_counter, a 16-bit wrapping counter with async active-low reset and an increment enable, instantiated three times.

Test Plan:
- Write addr 0x005 data 0xA5C3, then read addr 0x005 → write rsp_valid 2 edges after accept with rsp_rdata=0xA5C3 and rsp_err=0; read rsp_valid 3 edges after accept with rsp_rdata=0xA5C3; wr_count=1, rd_count=1.
- DEPTH=512, read addr 0x200 → rsp_valid 1 edge after accept, rsp_err=1, rsp_rdata=0, mem_we never high, err_count=1.
- rsp_ready held low for 5 cycles after rsp_valid → rsp_valid/rsp_rdata stable; req_ready=0 throughout; request presented meanwhile accepted only after completion plus one IDLE cycle.
- Change req_addr/req_wdata the cycle after accepting a write to 0x010 data 0x1234 → RAM at 0x010 = 0x1234; mem_we high exactly one cycle.
- Assert reset during ACCESS of a write → mem_we=0 and rsp_valid=0 immediately (before the next edge); counters=0; req_ready=1.
- Preload wr_count to 0xFFFF via 65535 writes (or force), then one more write → wr_count=0x0000.
